// File: rtl/digit_serial_adder.sv
// Purpose : multi-cycle adder/subtractor, DIGIT bits per clock through a ripple slice with a registered carry.
// Latency : done pulses N = WIDTH/DIGIT cycles after an accepted start; one result per N+1 cycles back-to-back.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted immediately.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request, sampled only when not busy
//   sub             0: a + b + cin, 1: a - b (cin ignored)
//   a, b, cin       operands, captured on an accepted start
//   busy            high while digits are being processed
//   done            one-cycle pulse, sum/cout (and ovf) valid
//   sum, cout       result and carry out of the MSB (for subtract, 1 = no borrow); held until next accept
//   ovf             signed overflow, present only when OVF_DETECT_EN is defined
//
// Optional feature macro: OVF_DETECT_EN (adds the ovf output and its register).
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef OVF_DETECT_EN
   ,
   output logic             ovf
`endif
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("digit_serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   a_sh, b_sh;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic [DIGIT:0]     c;
   logic [DIGIT-1:0]   s;
   logic [WIDTH-1:0]   sum_next;
   logic               accept, last;

   assign accept = start && (state != S_RUN);
   assign last   = (state == S_RUN) && (cnt == CNT_W'(N - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next state and handshake outputs
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         S_IDLE: if (start) state_n = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (last) state_n = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = start ? S_RUN : S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // DIGIT-wide ripple slice; c[DIGIT-1] is the carry into the slice MSB,
   // which on the final digit is the carry into the word MSB.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = carry;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a_sh[i] ^ b_sh[i] ^ c[i];
         c[i+1] = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
      end
   end

   // Result digits enter at the top so the first (least significant) digit
   // ends up at the bottom after N shifts.
   generate
      if (DIGIT == WIDTH) begin : g_full
         assign sum_next = s;
      end else begin : g_part
         assign sum_next = {s, sum[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef OVF_DETECT_EN
         ovf   <= 1'b0;
`endif
      end else if (accept) begin
         // Subtract as a + ~b + 1: invert B and seed the carry with 1.
         a_sh  <= a;
         b_sh  <= b ^ {WIDTH{sub}};
         carry <= sub ? 1'b1 : cin;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         a_sh  <= a_sh >> DIGIT;
         b_sh  <= b_sh >> DIGIT;
         carry <= c[DIGIT];
         cnt   <= cnt + 1'b1;
         sum   <= sum_next;
         if (last) begin
            cout <= c[DIGIT];
`ifdef OVF_DETECT_EN
            ovf  <= c[DIGIT-1] ^ c[DIGIT];
`endif
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Purpose : directed checks of digit_serial_adder at DIGIT=4, plus golden-model runs at DIGIT=1 and DIGIT=16.
// Latency : checks done arrives exactly N cycles after accept and back-to-back spacing of N+1.
// Backpressure: exercises start while busy (ignored) and start in the done cycle (accepted).
module tb_digit_serial_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sub = 1'b0;
   logic        cin = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
   logic        busy0, busy1, busy2, done0, done1, done2;
   logic        cout0, cout1, cout2;
   logic [15:0] sum0, sum1, sum2;
`ifdef OVF_DETECT_EN
   logic        ovf0, ovf1, ovf2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst(rst), .start(st0), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
`ifdef OVF_DETECT_EN
      , .ovf(ovf0)
`endif
   );
   digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .start(st1), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef OVF_DETECT_EN
      , .ovf(ovf1)
`endif
   );
   digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u2 (
      .clk(clk), .rst(rst), .start(st2), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef OVF_DETECT_EN
      , .ovf(ovf2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
   endfunction
   function automatic logic get_done(input int sel);
      return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
   endfunction
   function automatic logic get_cout(input int sel);
      return (sel == 0) ? cout0 : (sel == 1) ? cout1 : cout2;
   endfunction
   function automatic logic [15:0] get_sum(input int sel);
      return (sel == 0) ? sum0 : (sel == 1) ? sum1 : sum2;
   endfunction
`ifdef OVF_DETECT_EN
   function automatic logic get_ovf(input int sel);
      return (sel == 0) ? ovf0 : (sel == 1) ? ovf1 : ovf2;
   endfunction
`endif

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       st0 = v;
         1:       st1 = v;
         default: st2 = v;
      endcase
   endtask

   // Drive operands, raise start for exactly one edge (the accept edge).
   task automatic launch(input int sel, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic is);
      @(negedge clk);
      a = ia; b = ib; cin = ic; sub = is;
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      chk("busy_after_accept", {31'd0, get_busy(sel)}, 32'd1);
   endtask

   // Count edges until done is seen; 60 means it never came.
   task automatic wait_done(input int sel, input int from, output int lat);
      lat = from;
      while (lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (get_done(sel)) break;
      end
   endtask

   task automatic check_result(input string tag, input int sel, input int lat, input int exp_lat,
                               input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_sum"}, {16'd0, get_sum(sel)}, {16'd0, exp_sum});
      chk({tag, "_cout"}, {31'd0, get_cout(sel)}, {31'd0, exp_cout});
      chk({tag, "_busy_at_done"}, {31'd0, get_busy(sel)}, 32'd0);
`ifdef OVF_DETECT_EN
      chk({tag, "_ovf"}, {31'd0, get_ovf(sel)}, {31'd0, exp_ovf});
`else
      if (exp_ovf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
   endtask

   task automatic golden(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is,
                         output logic [15:0] gs, output logic gc, output logic go);
      logic [15:0] bb;
      logic [16:0] r;
      bb = is ? ~ib : ib;
      r  = {1'b0, ia} + {1'b0, bb} + {16'd0, (is ? 1'b1 : ic)};
      gs = r[15:0];
      gc = r[16];
      go = (ia[15] == bb[15]) && (r[15] != ia[15]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      int          done_cnt;
      logic [15:0] ra, rb, gs;
      logic        rc, rs, gc, go;

      // Reset state
      #12;
      chk("reset_busy", {31'd0, busy0}, 32'd0);
      chk("reset_done", {31'd0, done0}, 32'd0);
      chk("reset_sum", {16'd0, sum0}, 32'd0);
      chk("reset_cout", {31'd0, cout0}, 32'd0);
`ifdef OVF_DETECT_EN
      chk("reset_ovf", {31'd0, ovf0}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Plain add
      launch(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_done(0, 0, lat);
      check_result("t1", 0, lat, 4, 16'h5555, 1'b0, 1'b0);

      // Carry out of the MSB, with and without carry-in
      launch(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done(0, 0, lat);
      check_result("t2a", 0, lat, 4, 16'h0000, 1'b1, 1'b0);
      launch(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
      wait_done(0, 0, lat);
      check_result("t2b", 0, lat, 4, 16'h0001, 1'b1, 1'b0);

      // Subtract with and without borrow; cin must be ignored
      launch(0, 16'h0007, 16'h0005, 1'b1, 1'b1);
      wait_done(0, 0, lat);
      check_result("t3a", 0, lat, 4, 16'h0002, 1'b1, 1'b0);
      launch(0, 16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_done(0, 0, lat);
      check_result("t3b", 0, lat, 4, 16'hFFFE, 1'b0, 1'b0);

      // Signed overflow cases
      launch(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_done(0, 0, lat);
      check_result("t4a", 0, lat, 4, 16'h8000, 1'b0, 1'b1);
      launch(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_done(0, 0, lat);
      check_result("t4b", 0, lat, 4, 16'h7FFF, 1'b1, 1'b1);

      // Result holds after done with no new start
      repeat (3) @(posedge clk);
      #1;
      chk("hold_sum", {16'd0, sum0}, 32'h7FFF);
      chk("hold_done_low", {31'd0, done0}, 32'd0);

      // Start while busy is ignored
      launch(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      a = 16'hFFFF; b = 16'h0001; st0 = 1'b1;
      @(posedge clk);
      #1;
      st0 = 1'b0; a = 16'h0000; b = 16'h0000;
      chk("t5_busy_ignored", {31'd0, busy0}, 32'd1);
      wait_done(0, 2, lat);
      check_result("t5a", 0, lat, 4, 16'h5555, 1'b0, 1'b0);

      // Start in the done cycle is accepted; next done 5 cycles later
      a = 16'h0007; b = 16'h0005; sub = 1'b1; cin = 1'b0; st0 = 1'b1;
      @(posedge clk);
      #1;
      st0 = 1'b0;
      chk("t5_done_one_cycle", {31'd0, done0}, 32'd0);
      chk("t5_busy_b2b", {31'd0, busy0}, 32'd1);
      wait_done(0, 1, lat);
      check_result("t5b", 0, lat, 5, 16'h0002, 1'b1, 1'b0);

      // Reset mid-run: immediate clear, no done afterwards
      launch(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("t6_busy_before_rst", {31'd0, busy0}, 32'd1);
      chk("t6_sum_partial", {16'd0, sum0}, 32'hFF00);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", {31'd0, busy0}, 32'd0);
      chk("t6_rst_done", {31'd0, done0}, 32'd0);
      chk("t6_rst_sum", {16'd0, sum0}, 32'd0);
      chk("t6_rst_cout", {31'd0, cout0}, 32'd0);
`ifdef OVF_DETECT_EN
      chk("t6_rst_ovf", {31'd0, ovf0}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done0 || busy0) done_cnt++;
      end
      chk("t6_no_done_after_abort", done_cnt, 0);

      // Bit-serial instance vs golden model
      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         golden(ra, rb, rc, rs, gs, gc, go);
         launch(1, ra, rb, rc, rs);
         wait_done(1, 0, lat);
         check_result("rand_d1", 1, lat, 16, gs, gc, go);
      end

      // Full-width instance vs golden model
      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         golden(ra, rb, rc, rs, gs, gc, go);
         launch(2, ra, rb, rc, rs);
         wait_done(2, 0, lat);
         check_result("rand_d16", 2, lat, 1, gs, gc, go);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
